// File: rtl/dht22_display_pkg.sv
// Shared constants for the DHT22 seven-segment display: active-low gfedcba
// segment patterns and the digit-slot layout.
package dht22_display_pkg;

   localparam int NUM_DIGITS = 8;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;

   typedef enum logic [2:0] {
      SLOT_H_TENTHS = 3'd0,
      SLOT_H_UNITS  = 3'd1,
      SLOT_H_TENS   = 3'd2,
      SLOT_GAP      = 3'd3,
      SLOT_T_TENTHS = 3'd4,
      SLOT_T_UNITS  = 3'd5,
      SLOT_T_TENS   = 3'd6,
      SLOT_SIGN     = 3'd7
   } slot_e;

endpackage

// File: rtl/seg7_decoder.sv
// BCD to active-low seven-segment pattern; blank overrides dash, codes 10..15 show 'E'.
module seg7_decoder
   import dht22_display_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   input  logic       dash,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (blank)     seg = SEG_BLANK;
      else if (dash) seg = SEG_DASH;
      else begin
         case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
         endcase
      end
   end

endmodule

// File: rtl/dht22_display.sv
// Latches DHT22 BCD readings and scans them onto an 8-digit multiplexed display.
// Optional DHT22_DISPLAY_ZERO_BLANK_EN blanks zero tens digits.
module dht22_display
   import dht22_display_pkg::*;
#(
   parameter int CLK_FREQ   = 100000000,
   parameter int REFRESH_HZ = 1000,
   parameter int STALE_MS   = 5000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_ready,
   input  logic [11:0] humidity_bcd,
   input  logic [11:0] temperature_bcd,
   input  logic        negativo_temp,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        valid
);

   localparam int TICKS    = CLK_FREQ / (REFRESH_HZ * NUM_DIGITS);
   localparam int MS_TICKS = CLK_FREQ / 1000;
   localparam int TW = $clog2(TICKS + 1);
   localparam int MW = $clog2(MS_TICKS + 1);
   localparam int SW = $clog2(STALE_MS + 1);
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS - 1);
   localparam logic [MW-1:0] PRE_LAST   = MW'(MS_TICKS - 1);
   localparam logic [SW-1:0] STALE_MAX  = SW'(STALE_MS);
   localparam logic [SW-1:0] STALE_LAST = SW'(STALE_MS - 1);

`ifdef DHT22_DISPLAY_ZERO_BLANK_EN
   localparam logic ZERO_BLANK = 1'b1;
`else
   localparam logic ZERO_BLANK = 1'b0;
`endif

   logic          dr_prev, cap_q;
   logic [11:0]   stg_hum, stg_tmp, hum, tmp;
   logic          stg_neg, neg;
   logic [MW-1:0] pre_cnt;
   logic [SW-1:0] ms_cnt;
   logic [TW-1:0] tick;
   slot_e         scan_idx;

   logic [3:0] sel_bcd;
   logic       sel_blank, sel_dash, sel_dp;
   logic [6:0] dec_seg;

   always_comb begin
      sel_bcd   = 4'd0;
      sel_blank = 1'b0;
      sel_dash  = 1'b0;
      sel_dp    = 1'b1;
      if (!valid) begin
         sel_blank = (scan_idx == SLOT_GAP);
         sel_dash  = (scan_idx != SLOT_GAP);
      end else begin
         case (scan_idx)
            SLOT_SIGN:     begin sel_dash = neg; sel_blank = ~neg; end
            SLOT_T_TENS:   begin sel_bcd = tmp[11:8]; sel_blank = ZERO_BLANK && (tmp[11:8] == 4'd0); end
            SLOT_T_UNITS:  begin sel_bcd = tmp[7:4]; sel_dp = 1'b0; end
            SLOT_T_TENTHS: sel_bcd = tmp[3:0];
            SLOT_GAP:      sel_blank = 1'b1;
            SLOT_H_TENS:   begin sel_bcd = hum[11:8]; sel_blank = ZERO_BLANK && (hum[11:8] == 4'd0); end
            SLOT_H_UNITS:  begin sel_bcd = hum[7:4]; sel_dp = 1'b0; end
            SLOT_H_TENTHS: sel_bcd = hum[3:0];
         endcase
      end
   end

   seg7_decoder u_dec (
      .bcd   (sel_bcd),
      .blank (sel_blank),
      .dash  (sel_dash),
      .seg   (dec_seg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         dr_prev  <= 1'b0;
         cap_q    <= 1'b0;
         stg_hum  <= '0;
         stg_tmp  <= '0;
         stg_neg  <= 1'b0;
         hum      <= '0;
         tmp      <= '0;
         neg      <= 1'b0;
         valid    <= 1'b0;
         pre_cnt  <= '0;
         ms_cnt   <= '0;
         tick     <= '0;
         scan_idx <= SLOT_H_TENTHS;
         an       <= 8'hFF;
         seg      <= SEG_BLANK;
         dp       <= 1'b1;
      end else begin
         // Inputs are staged alongside the edge detect so the latch sees the
         // values present on the rising-edge cycle, not those a cycle later.
         dr_prev <= data_ready;
         cap_q   <= data_ready & ~dr_prev;
         stg_hum <= humidity_bcd;
         stg_tmp <= temperature_bcd;
         stg_neg <= negativo_temp;

         if (cap_q) begin
            hum     <= stg_hum;
            tmp     <= stg_tmp;
            neg     <= stg_neg;
            valid   <= 1'b1;
            pre_cnt <= '0;
            ms_cnt  <= '0;
         end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            if (ms_cnt < STALE_MAX)   ms_cnt <= ms_cnt + 1'b1;
            if (ms_cnt >= STALE_LAST) valid  <= 1'b0;
         end else begin
            pre_cnt <= pre_cnt + 1'b1;
         end

         // Pins load the current slot at its wrap, so the first enable lags reset by one slot.
         if (tick == TICK_LAST) begin
            tick     <= '0;
            an       <= ~(8'd1 << scan_idx);
            seg      <= dec_seg;
            dp       <= sel_dp;
            scan_idx <= slot_e'(scan_idx + 3'd1);
         end else begin
            tick <= tick + 1'b1;
         end
      end
   end

endmodule
